vga_scanout: RTL

Read-side scan-out engine for the 256×256, 12-bit pixel framebuffer that the drawing sequencer fills through its CounterX/CounterY/color write port. Generates 640×480@60 VGA timing from a pixel clock-enable, reads the framebuffer in raster order, and drives sync, data-enable and RGB to the DAC. A one-cycle frame_done pulse at the start of vertical blanking lets the drawing sequencer pace its clear/draw cycle to the display.

---
 rtl/vga_scanout_if.sv | 10 +
 rtl/vga_scanout.sv | 139 +++++++++++++
 2 files changed

// File: rtl/vga_scanout_if.sv
// Framebuffer read port between vga_scanout (master) and the pixel RAM (slave).
// rd_data is valid one clk after an rd_en strobe and held until the next read.
interface vga_scanout_if;
  logic [15:0] rd_addr;
  logic        rd_en;
  logic [11:0] rd_data;

  modport master (output rd_addr, output rd_en, input rd_data);
  modport slave  (input rd_addr, input rd_en, output rd_data);
endinterface

// File: rtl/vga_scanout.sv
// 640x480@60 VGA scan-out of a 256x256x12 framebuffer window, two-stage pixel pipeline.
// Optional macro VGA_SCANOUT_BORDER_EN: active pixels outside the window show BORDER_COLOR.
module vga_scanout #(
  parameter int          H_ACTIVE     = 640,
  parameter int          H_FP         = 16,
  parameter int          H_SYNC       = 96,
  parameter int          H_BP         = 48,
  parameter int          V_ACTIVE     = 480,
  parameter int          V_FP         = 10,
  parameter int          V_SYNC       = 2,
  parameter int          V_BP         = 33,
  parameter int          X_OFF        = 192,
  parameter int          Y_OFF        = 112,
  parameter logic [11:0] BORDER_COLOR = 12'h00F
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_ce,
  vga_scanout_if.master fb,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [11:0]   rgb,
  output logic          frame_done
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int SPAN_H  = (H_TOTAL > X_OFF + 257) ? H_TOTAL : X_OFF + 257;
  localparam int SPAN_V  = (V_TOTAL > Y_OFF + 257) ? V_TOTAL : Y_OFF + 257;
  localparam int CW      = $clog2((SPAN_H > SPAN_V) ? SPAN_H : SPAN_V);

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] V_FD   = CW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] X_BEG  = CW'(X_OFF);
  localparam logic [CW-1:0] X_END  = CW'(X_OFF + 256);
  localparam logic [CW-1:0] Y_BEG  = CW'(Y_OFF);
  localparam logic [CW-1:0] Y_END  = CW'(Y_OFF + 256);

`ifdef VGA_SCANOUT_BORDER_EN
  localparam logic [11:0] BORDER = BORDER_COLOR;
`else
  localparam logic [11:0] BORDER = BORDER_COLOR & 12'h000;
`endif

  function automatic logic is_act(input logic [CW-1:0] h, input logic [CW-1:0] v);
    return (h < H_ACT) && (v < V_ACT);
  endfunction

  function automatic logic is_win(input logic [CW-1:0] h, input logic [CW-1:0] v);
    return is_act(h, v) && (h >= X_BEG) && (h < X_END) && (v >= Y_BEG) && (v < Y_END);
  endfunction

  logic [CW-1:0] h_cnt, v_cnt;
  logic [CW-1:0] h_nxt, v_nxt;

  always_comb begin
    h_nxt = h_cnt + CW'(1);
    v_nxt = v_cnt;
    if (h_cnt == H_LAST) begin
      h_nxt = '0;
      v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_ce) begin
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
    end
  end

  // Read request and frame_done are decoded one position ahead so that, while the
  // counters sit at (h,v), the strobe for (h,v) is already registered and only
  // needs gating with pix_ce; the RAM then returns data in time for stage 2.
  logic [15:0] rd_addr_q;
  logic        rd_pend;
  logic        fd_arm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr_q <= '0;
      rd_pend   <= 1'b0;
      fd_arm    <= 1'b0;
    end else if (pix_ce) begin
      rd_pend <= is_win(h_nxt, v_nxt);
      fd_arm  <= (h_nxt == H_LAST) && (v_nxt == V_FD);
      if (is_win(h_nxt, v_nxt))
        rd_addr_q <= {8'(v_nxt - Y_BEG), 8'(h_nxt - X_BEG)};
    end
  end

  assign fb.rd_addr = rd_addr_q;
  assign fb.rd_en   = rd_pend & pix_ce;
  assign frame_done = fd_arm & pix_ce;

  // Stage 1: position flags travel alongside the outstanding RAM read.
  logic hs1, vs1, act1, win1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs1  <= 1'b1;
      vs1  <= 1'b1;
      act1 <= 1'b0;
      win1 <= 1'b0;
    end else if (pix_ce) begin
      hs1  <= !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
      vs1  <= !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
      act1 <= is_act(h_cnt, v_cnt);
      win1 <= is_win(h_cnt, v_cnt);
    end
  end

  // Stage 2: registered DAC outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      de    <= 1'b0;
      rgb   <= '0;
    end else if (pix_ce) begin
      hsync <= hs1;
      vsync <= vs1;
      de    <= act1;
      rgb   <= win1 ? fb.rd_data : (act1 ? BORDER : '0);
    end
  end

endmodule
